// File: rtl/mask_loader_pkg.sv
// Shared types and widths for the mask_loader block.
package mask_loader_pkg;

    localparam int MASK_WORD_W  = 16;
    localparam int MASK_COUNT_W = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mask_loader_if.sv
// Control, memory read port and renderer write port of mask_loader.
// The optional checksum signals exist only when MASK_LOADER_CHECKSUM_EN is defined.
interface mask_loader_if #(
    parameter int ADDR_WIDTH = 25
);
    import mask_loader_pkg::*;

    // Memory handshake: a request transfers on a cycle where mem_rd && mem_ready;
    // mem_rd/mem_addr hold until then. mem_data_valid has no back-pressure and
    // returns one word per cycle in request order.
    logic                    start;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [MASK_COUNT_W-1:0] word_count;
    logic                    busy;
    logic                    done;
    logic                    mem_rd;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_ready;
    logic                    mem_data_valid;
    logic [MASK_WORD_W-1:0]  mem_data;
    logic                    mask_data_wr;
    logic [MASK_WORD_W-1:0]  mask_data;

`ifdef MASK_LOADER_CHECKSUM_EN
    logic [MASK_WORD_W-1:0]  expected_sum;
    logic                    sum_ok;

    modport master (
        input  start, base_addr, word_count, mem_ready, mem_data_valid, mem_data, expected_sum,
        output busy, done, mem_rd, mem_addr, mask_data_wr, mask_data, sum_ok
    );
    modport slave (
        output start, base_addr, word_count, mem_ready, mem_data_valid, mem_data, expected_sum,
        input  busy, done, mem_rd, mem_addr, mask_data_wr, mask_data, sum_ok
    );
`else
    modport master (
        input  start, base_addr, word_count, mem_ready, mem_data_valid, mem_data,
        output busy, done, mem_rd, mem_addr, mask_data_wr, mask_data
    );
    modport slave (
        output start, base_addr, word_count, mem_ready, mem_data_valid, mem_data,
        input  busy, done, mem_rd, mem_addr, mask_data_wr, mask_data
    );
`endif

endinterface

// File: rtl/mask_fifo.sv
// Single-clock in-order prefetch FIFO; DEPTH must be a power of two.
module mask_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != FULL_COUNT) || w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mask_loader.sv
// Streams a word block from memory into the LCD mask port, with credit-limited
// prefetch and paced write strobes. MASK_LOADER_CHECKSUM_EN adds a word-sum check.
module mask_loader
    import mask_loader_pkg::*;
#(
    parameter int CLOCK_RATIO = 3,
    parameter int ADDR_WIDTH  = 25,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mask_loader_if.master bus,
    output state_t        o_dbg_state
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (CLOCK_RATIO > 1) ? $clog2(CLOCK_RATIO) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CLOCK_RATIO - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [MASK_COUNT_W-1:0] r_issue_left;
    logic [MASK_COUNT_W-1:0] r_write_left;
    logic [CNT_W-1:0]        r_outstanding;
    logic [GAP_W-1:0]        r_gap;
    logic                    r_mask_wr;
    logic [MASK_WORD_W-1:0]  r_mask_data;

    logic                    w_start_ok;
    logic                    w_rd_req;
    logic                    w_accept;
    logic                    w_ret;
    logic                    w_emit_en;
    logic                    w_pop;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_fifo_empty;
    logic [CNT_W-1:0]        w_fifo_count;
    logic [MASK_WORD_W-1:0]  w_fifo_data;
    logic [CNT_W:0]          w_credit_used;

    // Words buffered plus words in flight never exceed the FIFO depth,
    // so every returning word is guaranteed a slot.
    assign w_start_ok    = (r_state == IDLE) && bus.start;
    assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_rd_req      = (r_state == ISSUE) && (w_credit_used < CREDIT_MAX);
    assign w_accept      = w_rd_req && bus.mem_ready;
    assign w_ret         = bus.mem_data_valid && (r_outstanding != '0);
    assign w_emit_en     = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_pop         = w_emit_en && !w_fifo_empty && (r_gap == '0);

    mask_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MASK_WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_ret),
        .i_data  (bus.mem_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_next = (bus.word_count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (w_accept && (r_issue_left == MASK_COUNT_W'(1))) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_write_left == '0) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_issue_left  <= '0;
            r_write_left  <= '0;
            r_outstanding <= '0;
            r_gap         <= '0;
            r_mask_wr     <= 1'b0;
            r_mask_data   <= '0;
        end else begin
            r_mask_wr <= w_pop;
            if (w_pop) begin
                r_mask_data <= w_fifo_data;
            end
            if (w_pop) begin
                r_gap <= GAP_RELOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (w_start_ok) begin
                r_addr       <= bus.base_addr;
                r_issue_left <= bus.word_count;
                r_write_left <= bus.word_count;
            end else begin
                if (w_accept) begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_issue_left <= r_issue_left - MASK_COUNT_W'(1);
                end
                if (w_pop) begin
                    r_write_left <= r_write_left - MASK_COUNT_W'(1);
                end
            end
            case ({w_accept, w_ret})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

`ifdef MASK_LOADER_CHECKSUM_EN
    logic [MASK_WORD_W-1:0] r_sum;
    logic [MASK_WORD_W-1:0] r_exp_sum;
    logic                   r_sum_ok;

    // The verdict is registered on entry to FINISH so it is already valid while done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum     <= '0;
            r_exp_sum <= '0;
            r_sum_ok  <= 1'b0;
        end else if (w_start_ok) begin
            r_sum     <= '0;
            r_exp_sum <= bus.expected_sum;
            r_sum_ok  <= (bus.word_count == '0) && (bus.expected_sum == '0);
        end else begin
            if (w_pop) begin
                r_sum <= r_sum + w_fifo_data;
            end
            if ((r_state == DRAIN) && (w_state_next == FINISH)) begin
                r_sum_ok <= (r_sum == r_exp_sum);
            end
        end
    end

    assign bus.sum_ok = r_sum_ok;
`endif

    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.mem_rd       = w_rd_req;
    assign bus.mem_addr     = r_addr;
    assign bus.mask_data_wr = r_mask_wr;
    assign bus.mask_data    = r_mask_data;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mask_loader.sv
// Randomized scoreboard bench for mask_loader with a latency-modelling memory.
module tb_mask_loader;
    import mask_loader_pkg::*;

    localparam int CR    = 3;
    localparam int AW    = 25;
    localparam int DEPTH = 4;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b0;
    state_t dbg_state;
    int     cyc     = 0;
    int     n_vec   = 0;
    int     n_err   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mask_loader_if #(.ADDR_WIDTH(AW)) bus ();

    mask_loader #(
        .CLOCK_RATIO (CR),
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // scoreboard state
    logic [15:0]   exp_q[$];
    logic [AW-1:0] cur_base    = '0;
    int            cur_count   = 0;
    int            acc_cnt     = 0;
    int            wr_cnt      = 0;
    int            done_cnt    = 0;
    int            last_wr_cyc = 0;
    bit            first_wr    = 1'b1;
    bit            fast_mode   = 1'b0;
    bit            prev_stall  = 1'b0;
    logic [AW-1:0] prev_addr   = '0;

    // memory model state
    logic [AW-1:0] mq_addr[$];
    int            mq_due[$];
    int            last_due = 0;
    int            lat_min  = 2;
    int            lat_max  = 2;
    bit            rdy_rand = 1'b0;
    bit            use_tbl  = 1'b0;
    logic [15:0]   tbl [4];

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        if (use_tbl) return tbl[a[1:0]];
        return a[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory response driver
    initial begin
        bus.mem_ready      = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data       = mem_word(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                bus.mem_data_valid = 1'b0;
                bus.mem_data       = 16'($urandom);
            end
        end
    end

    // request capture and output monitor
    initial begin
        forever begin
            logic [15:0]   w;
            logic [AW-1:0] ea;
            int            d;
            @(negedge clk);
            if (bus.mem_rd && bus.mem_ready) begin
                d = cyc + int'($urandom_range(lat_min, lat_max));
                if (d < last_due) d = last_due;
                last_due = d;
                mq_addr.push_back(bus.mem_addr);
                mq_due.push_back(d);
            end
            if (!reset_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("rd_hold", 32'(bus.mem_rd), 32'd1);
                chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
            end
            prev_stall = bus.mem_rd && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            if (bus.mem_rd && bus.mem_ready) begin
                ea = cur_base + AW'(acc_cnt);
                chk("rd_in_range", 32'(acc_cnt < cur_count), 32'd1);
                chk("rd_addr", 32'(bus.mem_addr), 32'(ea));
                acc_cnt++;
            end
            if (bus.mask_data_wr) begin
                if (exp_q.size() == 0) begin
                    chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_data", 32'(bus.mask_data), 32'(w));
                    if (!first_wr) begin
                        if (fast_mode) chk("wr_spacing", 32'(cyc - last_wr_cyc), 32'(CR));
                        else chk("wr_spacing_min", 32'((cyc - last_wr_cyc) >= CR), 32'd1);
                    end
                end
                first_wr    = 1'b0;
                last_wr_cyc = cyc;
                wr_cnt++;
            end
            if (acc_cnt - wr_cnt > DEPTH) begin
                chk("credit_limit", 32'(acc_cnt - wr_cnt), 32'(DEPTH));
            end
            if (bus.done) begin
                done_cnt++;
                if (cur_count > 0) chk("done_after_last_wr", 32'(cyc - last_wr_cyc), 32'd1);
            end
        end
    end

    task automatic start_load(input logic [AW-1:0] base, input int count);
        @(posedge clk);
        #1;
        cur_base  = base;
        cur_count = count;
        acc_cnt   = 0;
        wr_cnt    = 0;
        done_cnt  = 0;
        first_wr  = 1'b1;
        for (int i = 0; i < count; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            exp_q.push_back(mem_word(a));
        end
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = 20'(count);
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.base_addr  = AW'($urandom);
        bus.word_count = 20'($urandom);
        chk("busy_n1", 32'(bus.busy), 32'd1);
        chk("rd_n1", 32'(bus.mem_rd), 32'(count > 0));
        chk("done_n1", 32'(bus.done), 32'(count == 0));
        if (count > 0) chk("addr_n1", 32'(bus.mem_addr), 32'(base));
    endtask

    task automatic wait_done(input int budget, input int restart_at);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (i == restart_at) begin
                bus.start      = 1'b1;
                bus.base_addr  = AW'($urandom);
                bus.word_count = 20'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            #1;
            if (done_cnt > 0) begin
                got = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        #1;
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("all_written", 32'(wr_cnt), 32'(cur_count));
        chk("reads_issued", 32'(acc_cnt), 32'(cur_count));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        chk({tag, "_wr"}, 32'(bus.mask_data_wr), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mask_data"}, 32'(bus.mask_data), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        bit got;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
`ifdef MASK_LOADER_CHECKSUM_EN
        bus.expected_sum = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // fast memory: exact pacing
        lat_min = 2; lat_max = 2; rdy_rand = 1'b0; fast_mode = 1'b1;
        start_load(25'h100, 8);
        wait_done(300, -1);
        fast_mode = 1'b0;

        // random ready and latency
        lat_min = 1; lat_max = 10; rdy_rand = 1'b1;
        start_load(AW'($urandom), 37);
        wait_done(3000, -1);

        // empty load
        rdy_rand = 1'b0;
        start_load(AW'($urandom), 0);
        wait_done(20, -1);

        // start while busy is ignored
        rdy_rand = 1'b1;
        start_load(25'h3000, 12);
        wait_done(1500, 6);

        // reset mid-load with data still in flight
        lat_min = 4; lat_max = 10;
        start_load(25'h0400, 20);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt >= 3) begin
                got = 1'b1;
                break;
            end
        end
        chk("three_writes", 32'(got), 32'd1);
        reset_n = 1'b0;
        exp_q.delete();
        cur_count = 0; acc_cnt = 0; wr_cnt = 0; done_cnt = 0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (mq_due.size() == 0) break;
        end
        repeat (5) @(posedge clk);
        #1;
        check_idle_outputs("postreset");
        chk("no_wr_after_reset", 32'(wr_cnt), 32'd0);
        chk("no_done_after_reset", 32'(done_cnt), 32'd0);

        // fresh load crossing the top of the address space
        start_load(25'h1FF_FFFC, 9);
        wait_done(1500, -1);

        for (int k = 0; k < 4; k++) begin
            start_load(AW'($urandom), int'($urandom_range(1, 15)));
            wait_done(1500, -1);
        end

`ifdef MASK_LOADER_CHECKSUM_EN
        use_tbl = 1'b1;
        tbl[0] = 16'hFFFF; tbl[1] = 16'h0001; tbl[2] = 16'h1234; tbl[3] = 16'h0000;
        bus.expected_sum = 16'h1234;
        start_load(25'h200, 4);
        wait_done(500, -1);
        chk("sum_ok_match", 32'(bus.sum_ok), 32'd1);
        bus.expected_sum = 16'h1235;
        start_load(25'h200, 4);
        wait_done(500, -1);
        chk("sum_ok_mismatch", 32'(bus.sum_ok), 32'd0);
        use_tbl = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
